// File: rtl/pipeline_control.sv
// Central stall/squash scheduler for the 7-stage pipeline.
// Combines the execute-stage redirect, decode load-use hazard, memory-busy
// freeze and debug halt/resume into per-stage stall and bubble controls,
// sequences the halt drain and keeps stall/flush performance counters.
//
// Ports:
//   clock         system clock
//   reset         asynchronous active-low reset
//   redirect      resolve stage takes a jump/branch this cycle
//   hazard_req    decode operand not ready; hold younger stages, bubble resolve stage
//   mem_busy      multi-cycle memory op in flight; freeze whole pipeline
//   halt_req      debug halt request (level)
//   resume        leave halted state (pulse)
//   stall         per-stage hold (bit i = stage i+1), combinational
//   bubble        per-stage valid-clear on next load, combinational
//   halted        pipeline empty and frozen
//   stall_cycles  cycles with any stall bit set, wraps
//   flush_count   accepted redirects, wraps
module pipeline_control #(
  parameter int unsigned NUM_STAGES    = 7,
  parameter int unsigned RESOLVE_STAGE = 3,
  parameter int unsigned FLUSH_SHADOW  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  redirect,
  input  logic                  hazard_req,
  input  logic                  mem_busy,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic [NUM_STAGES-1:0] stall,
  output logic [NUM_STAGES-1:0] bubble,
  output logic                  halted,
  output logic [31:0]           stall_cycles,
  output logic [15:0]           flush_count
);

  localparam int unsigned SHD_W = (FLUSH_SHADOW > 0) ? $clog2(FLUSH_SHADOW + 1) : 1;
  localparam int unsigned DRN_W = $clog2(NUM_STAGES);

  // Stages younger than the resolve stage: squashed on redirect, held on hazard.
  localparam logic [NUM_STAGES-1:0] YOUNG_MASK = NUM_STAGES'((2 ** (RESOLVE_STAGE - 1)) - 1);
  // Resolve stage itself: bubbled while the hazard holds the younger stages.
  localparam logic [NUM_STAGES-1:0] RES_MASK   = NUM_STAGES'(2 ** (RESOLVE_STAGE - 1));

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [SHD_W-1:0] shd, shd_nxt;
  logic [DRN_W-1:0] drn, drn_nxt;
  logic             flush_inc;

  // State, shadow and drain counters, plus performance counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= RUN;
      shd          <= '0;
      drn          <= '0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      state <= state_nxt;
      shd   <= shd_nxt;
      drn   <= drn_nxt;
      if (|stall) stall_cycles <= stall_cycles + 32'd1;
      if (flush_inc) flush_count <= flush_count + 16'd1;
    end
  end

  // Next state and per-stage controls.
  always_comb begin
    state_nxt = state;
    shd_nxt   = shd;
    drn_nxt   = drn;
    flush_inc = 1'b0;
    stall     = '0;
    bubble    = '0;

    if (!reset) begin
      bubble = '1;
    end else if (state == HALTED || mem_busy) begin
      // Full freeze: resolve stage holds and re-presents redirect/hazard later.
      stall = '1;
    end else begin
      if (redirect) begin
        // Hazarding instruction is squashed, so a concurrent hazard is dropped.
        bubble = bubble | YOUNG_MASK;
      end else if (hazard_req) begin
        stall  = stall | YOUNG_MASK;
        bubble = bubble | RES_MASK;
      end
      // Fetch latency shadow after a redirect keeps stage 1 invalid.
      if (shd != '0) bubble[0] = 1'b1;
      if (state == DRAIN) begin
        stall[0]  = 1'b1;
        bubble[1] = 1'b1;
      end
    end

    if (!mem_busy) begin
      if (state == HALTED) begin
        if (resume) state_nxt = RUN;
      end else begin
        if (redirect) begin
          shd_nxt   = SHD_W'(FLUSH_SHADOW);
          flush_inc = 1'b1;
        end else if (shd != '0) begin
          shd_nxt = shd - SHD_W'(1);
        end
        case (state)
          RUN: begin
            if (halt_req) begin
              state_nxt = DRAIN;
              drn_nxt   = DRN_W'(NUM_STAGES - 1);
            end
          end
          DRAIN: begin
            drn_nxt = drn - DRN_W'(1);
            if (drn == DRN_W'(1)) state_nxt = HALTED;
          end
          default: ;
        endcase
      end
    end
  end

  assign halted = (state == HALTED);

endmodule

// File: doc/pipeline_control.md
Name: pipeline_control

Overview:
Central stall/squash scheduler for the 7-stage pipeline.
- Takes the execute-stage redirect (taken branch/jal/jalr), the decode load-use hazard request, back-end memory-busy and debug halt/resume.
- Produces per-stage stall and bubble (valid-clear) controls.
- Sequences the halt drain.
- Keeps stall/flush performance counters.

Parameters:
- NUM_STAGES, 7: pipeline depth; bit i of every per-stage vector is stage i+1.
- RESOLVE_STAGE, 3: stage that resolves control flow; stages 1..RESOLVE_STAGE-1 are younger.
- FLUSH_SHADOW, 1: extra cycles after a redirect during which stage 1 is still bubbled, covering fetch latency (0..3).

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- redirect  input  1  stage 3 takes a jump/branch this cycle
- hazard_req  input  1  stage 2 operand not ready; hold stages 1-2, bubble stage 3
- mem_busy  input  1  multi-cycle memory op in flight; freeze whole pipeline
- halt_req  input  1  debug halt request (level)
- resume  input  1  leave halted state (pulse)
- stall  output  NUM_STAGES  per-stage hold; the stage register keeps its contents
- bubble  output  NUM_STAGES  per-stage valid-clear on the next load
- halted  output  1  pipeline empty and frozen
- stall_cycles  output  32  cycles with any stall bit set, wraps
- flush_count  output  16  accepted redirects, wraps

Behaviour:
- States: RUN, DRAIN, HALTED. A registered shadow counter shd holds 0..FLUSH_SHADOW. A registered drain counter drn holds 0..NUM_STAGES-1.
- Reset asserted (reset=0):
  - state=RUN, shd=0, drn=0, counters=0, halted=0.
  - stall=0, bubble=all ones.
  - Reset mid-drain or mid-halt returns to RUN.
- stall and bubble are combinational from the current state and inputs. Counters and state update on the rising clock edge.
- Priority within a cycle: mem_busy > redirect > hazard_req > halt sequencing.
- mem_busy=1, any state:
  - stall=all ones, bubble=0.
  - redirect and hazard_req ignored; stage 3 holds and re-presents them.
  - shd and drn paused, state unchanged.
- redirect=1 (not frozen):
  - bubble[0..RESOLVE_STAGE-2]=1; no stall.
  - shd<=FLUSH_SHADOW, flush_count+1.
  - A concurrent hazard_req is dropped because the hazarding instruction is squashed.
- shd>0 (not frozen): bubble[0]=1, shd decrements. A redirect reloads shd.
- hazard_req=1 (not frozen, no redirect): stall[0]=stall[1]=1, bubble[2]=1. Stages 4..7 advance.
- RUN to DRAIN: halt_req=1 in RUN, not frozen; drn<=NUM_STAGES-1.
- DRAIN:
  - stall[0]=1 (fetch held) and bubble[1]=1, OR'ed with the redirect/hazard terms.
  - drn decrements each unfrozen cycle; hazard cycles also count.
  - DRAIN to HALTED when drn==1 and the cycle is not frozen.
  - halt_req deasserting in DRAIN does not abort the drain.
- HALTED:
  - halted=1, stall=all ones, bubble=0; redirect and hazard_req ignored.
  - resume=1 goes to RUN next cycle, even if halt_req is still high.
  - From RUN, a still-high halt_req then re-enters DRAIN one cycle later.
  - resume outside HALTED is ignored.
- stall_cycles increments on every cycle where any stall bit is set, including HALTED.

Test Plan:
- Reset release, idle inputs: first cycle bubble=0x00, stall=0x00, counters 0. Hold reset=0 mid-run: bubble=0x7F, state RUN.
- redirect one cycle with FLUSH_SHADOW=1:
  - Cycle t: bubble=0x03.
  - Cycle t+1: bubble=0x01.
  - Cycle t+2: bubble=0x00; flush_count=1.
- hazard_req for 3 cycles: stall=0x03, bubble=0x04 each cycle; stall_cycles=3. With redirect concurrent: bubble=0x03, stall=0x00.
- mem_busy for 4 cycles during an active shadow (shd=1): stall=0x7F, bubble=0x00. On release, bubble=0x01 for one cycle. A redirect held throughout counts once, on the release cycle.
- halt_req pulse from RUN:
  - 6 cycles of stall[0]=1/bubble[1]=1, then halted=1, stall=0x7F.
  - resume: RUN next cycle, stall=0x00.
- halt_req with mem_busy for 2 cycles mid-drain: halted asserts 8 cycles after entry instead of 6. Reset during HALTED: halted=0 immediately.
